demux_1_to_4_32bit_buf: RTL and testbench

- Registered 1-to-4 dispatcher: one 32-bit valid/ready input stream is steered by a 2-bit select to one of four output channels.
- Each output channel has its own small FIFO buffer.
- This is the inverse of the team's 4-to-1 32-bit select mux. It fans a single datapath source out to four consumers, and a stalled consumer only blocks traffic addressed to itself.

---
 rtl/demux_1_to_4_32bit_buf_if.sv | 43 ++++
 rtl/demux_1_to_4_32bit_buf.sv | 64 ++++++
 tb/tb_demux_1_to_4_32bit_buf.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/demux_1_to_4_32bit_buf_if.sv
// Bus bundle for the 1-to-4 dispatcher: one valid/ready input stream in,
// four independent valid/ready output channels out.
interface demux_1_to_4_32bit_buf_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data_0;
    logic [WIDTH-1:0] out_data_1;
    logic [WIDTH-1:0] out_data_2;
    logic [WIDTH-1:0] out_data_3;

    // master drives the source side and the consumer ready lines
    modport master (
        output in_valid,
        output in_sel,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data_0,
        input  out_data_1,
        input  out_data_2,
        input  out_data_3
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data_0,
        output out_data_1,
        output out_data_2,
        output out_data_3
    );
endinterface

// File: rtl/demux_1_to_4_32bit_buf.sv
// Registered 1-to-4 dispatcher: the input word is steered by in_sel into one
// of four per-channel FIFOs so a stalled consumer only blocks its own traffic.
module demux_1_to_4_32bit_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    demux_1_to_4_32bit_buf_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [3:0][PTR_W:0]   cnt;
    logic [3:0][WIDTH-1:0] head;

    // A full channel still accepts when its head leaves in the same cycle.
    assign bus.in_ready = (cnt[bus.in_sel] != FULL_CNT) | bus.out_ready[bus.in_sel];

    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [PTR_W:0]   count;
        logic             push;
        logic             pop;

        assign push = bus.in_valid & bus.in_ready & (bus.in_sel == 2'(g));
        assign pop  = (count != '0) & bus.out_ready[g];

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    mem[k] <= '0;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr] <= bus.in_data;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end

        assign cnt[g]           = count;
        assign head[g]          = mem[rd_ptr];
        assign bus.out_valid[g] = (count != '0);
    end

    assign bus.out_data_0 = head[0];
    assign bus.out_data_1 = head[1];
    assign bus.out_data_2 = head[2];
    assign bus.out_data_3 = head[3];
endmodule

// File: tb/tb_demux_1_to_4_32bit_buf.sv
// Scoreboard bench for the 1-to-4 dispatcher: per-channel expected-word queues
// filled by the stimulus side, drained and compared by a negedge monitor.
module tb_demux_1_to_4_32bit_buf;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_1_to_4_32bit_buf_if #(.WIDTH(32)) bus ();

    demux_1_to_4_32bit_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] exp_q [4][$];
    int          checks   = 0;
    int          failures = 0;
    logic        last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] head_of(input int i);
        case (i)
            0:       return bus.out_data_0;
            1:       return bus.out_data_1;
            2:       return bus.out_data_2;
            default: return bus.out_data_3;
        endcase
    endfunction

    function automatic int total_pending();
        return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    endfunction

    // Monitor: model says a channel is valid iff its queue is non-empty; the
    // head word must match the oldest accepted word; a pop retires it.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready",
                {31'd0, bus.in_ready},
                {31'd0, (exp_q[bus.in_sel].size() != DEPTH) || bus.out_ready[bus.in_sel]});
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("out_valid_%0d", i), {31'd0, bus.out_valid[i]},
                    {31'd0, exp_q[i].size() != 0});
                if (exp_q[i].size() != 0) begin
                    chk($sformatf("out_data_%0d", i), head_of(i), exp_q[i][0]);
                    if (bus.out_ready[i]) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    // Drive one cycle; the accepted word (per model occupancy) is queued as expected.
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] r);
        @(posedge clk); #1;
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        @(negedge clk); #1;
        last_acc = v && (exp_q[s].size() < DEPTH);
        if (last_acc) exp_q[s].push_back(d);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'h0;
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {28'd0, bus.out_valid}, 32'd0);
        chk("rst_data_0", bus.out_data_0, 32'd0);
        chk("rst_data_1", bus.out_data_1, 32'd0);
        chk("rst_data_2", bus.out_data_2, 32'd0);
        chk("rst_data_3", bus.out_data_3, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (total_pending() != 0 && n < 50) begin
            step(1'b0, 2'd0, 32'd0, 4'hF);
            n++;
        end
        chk(name, total_pending(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words [6];
        int          idx;
        logic        tog;

        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = 32'd0;
        bus.out_ready = 4'h0;

        do_reset();

        // one word per channel, each visible one cycle after its push
        step(1'b1, 2'd0, 32'hA000_0001, 4'hF);
        step(1'b1, 2'd1, 32'hB000_0002, 4'hF);
        chk("onehot_0", {28'd0, bus.out_valid}, 32'h1);
        chk("word_ch0", bus.out_data_0, 32'hA000_0001);
        step(1'b1, 2'd2, 32'hC000_0003, 4'hF);
        chk("onehot_1", {28'd0, bus.out_valid}, 32'h2);
        chk("word_ch1", bus.out_data_1, 32'hB000_0002);
        step(1'b1, 2'd3, 32'hD000_0004, 4'hF);
        chk("onehot_2", {28'd0, bus.out_valid}, 32'h4);
        chk("word_ch2", bus.out_data_2, 32'hC000_0003);
        step(1'b0, 2'd0, 32'd0, 4'hF);
        chk("onehot_3", {28'd0, bus.out_valid}, 32'h8);
        chk("word_ch3", bus.out_data_3, 32'hD000_0004);
        step(1'b0, 2'd0, 32'd0, 4'hF);
        chk("onehot_idle", {28'd0, bus.out_valid}, 32'h0);

        // channel 2 stalled: fills at two, refuses the third, ch0 unaffected
        step(1'b1, 2'd2, 32'h1, 4'b1011);
        step(1'b1, 2'd2, 32'h2, 4'b1011);
        step(1'b1, 2'd2, 32'h3, 4'b1011);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("full_head", bus.out_data_2, 32'h1);
        step(1'b1, 2'd0, 32'h55, 4'b1011);
        chk("ch0_not_blocked", {31'd0, bus.in_ready}, 32'd1);

        // full channel accepts while its head is popped
        step(1'b1, 2'd2, 32'h3, 4'hF);
        chk("full_pop_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step(1'b0, 2'd0, 32'd0, 4'hF);
        chk("full_pop_valid", {31'd0, bus.out_valid[2]}, 32'd1);
        chk("full_pop_2nd", bus.out_data_2, 32'h2);
        step(1'b0, 2'd0, 32'd0, 4'hF);
        chk("full_pop_3rd", bus.out_data_2, 32'h3);
        step(1'b0, 2'd0, 32'd0, 4'hF);
        chk("full_pop_empty", {31'd0, bus.out_valid[2]}, 32'd0);

        // fill channels 0 and 3, then reset mid-stream
        step(1'b1, 2'd0, $urandom, 4'h0);
        step(1'b1, 2'd0, $urandom, 4'h0);
        step(1'b1, 2'd3, $urandom, 4'h0);
        step(1'b1, 2'd3, $urandom, 4'h0);
        do_reset();
        repeat (4) step(1'b0, 2'd0, 32'd0, 4'hF);

        // in_valid low: nothing enters whatever sel/data do
        repeat (10) step(1'b0, 2'($urandom), $urandom, 4'($urandom));
        chk("idle_out_valid", {28'd0, bus.out_valid}, 32'd0);

        // six words to ch1 with toggling consumer, across pointer wrap
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        idx = 0;
        tog = 1'b1;
        for (int cyc = 0; cyc < 100 && idx < 6; cyc++) begin
            step(1'b1, 2'd1, words[idx], {2'b11, tog, 1'b1});
            if (last_acc) idx++;
            tog = ~tog;
        end
        chk("stream_accepted", idx, 32'd6);
        drain("stream_drain");

        // randomized traffic on all channels
        for (int cyc = 0; cyc < 400; cyc++) begin
            step(1'($urandom), 2'($urandom), $urandom, 4'($urandom));
        end
        drain("random_drain");

        step(1'b0, 2'd0, 32'd0, 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
